// File: rtl/demux1_4_buf.sv
// -----------------------------------------------------------------------------
// demux1_4_buf
//
// Registered 1-to-4 demultiplexer with one holding register per output.
// A single valid/ready input stream carries a 2-bit destination select with
// each word. Every accepted word is steered into the holding register of the
// selected output. Each output then drains on its own valid/ready handshake.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    input word (WIDTH bits)
//   in_sel     destination output index 0..3
//   in_valid   in_data / in_sel valid
//   in_ready   input accepted this cycle (combinational, independent of in_valid)
//   out_data   packed outputs, output i at [i*WIDTH +: WIDTH]
//   out_valid  bit i set while holding register i is full
//   out_ready  bit i: consumer i takes slice i this cycle
//   xfer_cnt   (DEMUX1_4_STATS_EN only) 4 x 8-bit saturating per-output
//              counts of input transfers, slice i at [i*8 +: 8]
//
// Build option
//   DEMUX1_4_STATS_EN  when defined, adds the xfer_cnt port and its counters.
//                      When undefined, the port and counters are absent.
// -----------------------------------------------------------------------------
module demux1_4_buf #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [4*WIDTH-1:0]   out_data,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready
`ifdef DEMUX1_4_STATS_EN
   ,
   output logic [31:0]          xfer_cnt
`endif
);

   logic [WIDTH-1:0] r_data [4];
   logic [3:0]       r_full;

   logic [3:0]       w_sel_dec;
   logic             w_in_xfer;
   logic [3:0]       w_fill;
   logic [3:0]       w_drain;

   // A full slot can still accept when its consumer is draining in the
   // same cycle, giving one word per cycle per output.
   assign in_ready  = ~r_full[in_sel] | out_ready[in_sel];
   assign w_in_xfer = in_valid & in_ready;
   assign w_sel_dec = 4'b0001 << in_sel;
   assign w_fill    = {4{w_in_xfer}} & w_sel_dec;
   assign w_drain   = r_full & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_fill[i]) begin
               // Covers both fill-only and fill-with-drain: slot stays full.
               r_data[i] <= in_data;
               r_full[i] <= 1'b1;
            end else if (w_drain[i]) begin
               r_full[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_full;

   for (genvar g = 0; g < 4; g++) begin : g_out
      assign out_data[g*WIDTH +: WIDTH] = r_data[g];
   end

`ifdef DEMUX1_4_STATS_EN
   logic [7:0] r_cnt [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // Saturate at 255 rather than wrap.
            if (w_fill[i] && (r_cnt[i] != 8'hFF)) begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      assign xfer_cnt[g*8 +: 8] = r_cnt[g];
   end
`endif

endmodule

// File: tb/tb_demux1_4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1_4_buf
//
// Directed bench for demux1_4_buf. A table of per-cycle vectors covers reset,
// single routing, hold, backpressure/fill-with-drain and mid-operation reset.
// Hand-written sequences cover back-to-back streaming and, when built with
// DEMUX1_4_STATS_EN, counter saturation and clearing.
// -----------------------------------------------------------------------------
module tb_demux1_4_buf;

   localparam int WIDTH = 16;

   logic               clk;
   logic               rst;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
`ifdef DEMUX1_4_STATS_EN
   logic [31:0]        xfer_cnt;
`endif

   demux1_4_buf #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX1_4_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Source rule: a stalled word must be held until accepted.
   logic             p_stall = 1'b0;
   logic [WIDTH-1:0] p_data;
   logic [1:0]       p_sel;
   always @(posedge clk) begin
      if (p_stall && in_valid && ((in_data !== p_data) || (in_sel !== p_sel))) begin
         errors++;
         $display("FAIL src_hold: data %h sel %0d changed from data %h sel %0d while stalled",
                  in_data, in_sel, p_data, p_sel);
      end
      if (!rst && in_valid && (in_ready === 1'b0)) p_stall <= 1'b1;
      else                                          p_stall <= 1'b0;
      p_data <= in_data;
      p_sel  <= in_sel;
   end

   typedef struct {
      logic        rst;
      logic        vld;
      logic [1:0]  sel;
      logic [15:0] data;
      logic [3:0]  ordy;
      logic        chk_rdy;
      logic        exp_rdy;
      logic [3:0]  exp_ov;
      logic [63:0] exp_od;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   initial begin
      // rst  vld  sel   data      ordy    chk  rdy  ov       od (slice3_2_1_0)
      vecs[0]  = '{1'b1, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b0, 1'b0, 4'b0000, 64'h0};
      vecs[1]  = '{1'b1, 1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 4'b0000, 64'h0};
      vecs[2]  = '{1'b0, 1'b0, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 4'b0000, 64'h0};
      vecs[3]  = '{1'b0, 1'b1, 2'd1, 16'h1234, 4'b0000, 1'b1, 1'b1, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[4]  = '{1'b0, 1'b0, 2'd1, 16'h9999, 4'b0000, 1'b1, 1'b0, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'h9999, 4'b0000, 1'b1, 1'b1, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[6]  = '{1'b0, 1'b0, 2'd1, 16'h9999, 4'b0000, 1'b1, 1'b0, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[7]  = '{1'b0, 1'b0, 2'd1, 16'h9999, 4'b0000, 1'b1, 1'b0, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[8]  = '{1'b0, 1'b0, 2'd1, 16'h9999, 4'b0000, 1'b1, 1'b0, 4'b0010, 64'h0000_0000_1234_0000};
      vecs[9]  = '{1'b0, 1'b0, 2'd1, 16'h9999, 4'b0010, 1'b1, 1'b1, 4'b0000, 64'h0000_0000_1234_0000};
      vecs[10] = '{1'b0, 1'b1, 2'd3, 16'hAAAA, 4'b0000, 1'b1, 1'b1, 4'b1000, 64'hAAAA_0000_1234_0000};
      vecs[11] = '{1'b0, 1'b1, 2'd3, 16'h5555, 4'b0000, 1'b1, 1'b0, 4'b1000, 64'hAAAA_0000_1234_0000};
      vecs[12] = '{1'b0, 1'b1, 2'd3, 16'h5555, 4'b0000, 1'b1, 1'b0, 4'b1000, 64'hAAAA_0000_1234_0000};
      vecs[13] = '{1'b0, 1'b1, 2'd3, 16'h5555, 4'b1000, 1'b1, 1'b1, 4'b1000, 64'h5555_0000_1234_0000};
      vecs[14] = '{1'b0, 1'b1, 2'd0, 16'h0A0A, 4'b1000, 1'b1, 1'b1, 4'b0001, 64'h5555_0000_1234_0A0A};
      vecs[15] = '{1'b0, 1'b1, 2'd2, 16'h0C0C, 4'b0000, 1'b1, 1'b1, 4'b0101, 64'h5555_0C0C_1234_0A0A};
      vecs[16] = '{1'b1, 1'b0, 2'd0, 16'h0000, 4'b0101, 1'b1, 1'b1, 4'b0000, 64'h0};
      vecs[17] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 64'h0};
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
      @(posedge clk);
      #1;

      for (int v = 0; v < NVEC; v++) begin
         rst       = vecs[v].rst;
         in_valid  = vecs[v].vld;
         in_sel    = vecs[v].sel;
         in_data   = vecs[v].data;
         out_ready = vecs[v].ordy;
         @(negedge clk);
         if (vecs[v].chk_rdy)
            chk($sformatf("vec%0d_in_ready", v), {63'd0, in_ready}, {63'd0, vecs[v].exp_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid", v), {60'd0, out_valid}, {60'd0, vecs[v].exp_ov});
         chk($sformatf("vec%0d_out_data", v), out_data, vecs[v].exp_od);
      end

      // Back-to-back streaming with all consumers ready.
      rst       = 1'b0;
      out_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         logic [1:0] s;
         s        = 2'(i % 4);
         in_valid = 1'b1;
         in_sel   = s;
         in_data  = 16'(i);
         @(negedge clk);
         chk($sformatf("stream%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d_out_valid", i), {60'd0, out_valid}, {60'd0, 4'b0001 << s});
         chk($sformatf("stream%0d_slice", i), {48'd0, out_data[s*WIDTH +: WIDTH]}, 64'(i));
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("stream_drained", {60'd0, out_valid}, 64'd0);

`ifdef DEMUX1_4_STATS_EN
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 4'b0101;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 16'h0001;
      repeat (300) @(posedge clk);
      #1;
      in_sel = 2'd2;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("stats_sat", {32'd0, xfer_cnt}, {32'd0, 8'd0, 8'd3, 8'd0, 8'd255});
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("stats_clear", {32'd0, xfer_cnt}, 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
